// File: rtl/count_sequence_checker_pkg.sv
// Shared definitions for the count sequence: tracker states and the one
// definition of "next value" used by both the counter and its checker.
package count_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_e;

    localparam int MAX_COUNT_WIDTH = 16;

    typedef logic [MAX_COUNT_WIDTH-1:0] wide_count_t;

    // Callers zero-extend into the wide type and truncate the result back.
    // This is exact because limit always fits in the narrow count width.
    function automatic wide_count_t next_count(input wide_count_t v,
                                               input wide_count_t limit,
                                               input logic        up);
        if (up) begin
            return (v == limit) ? '0 : v + wide_count_t'(1);
        end
        return (v == '0) ? limit : v - wide_count_t'(1);
    endfunction

endpackage

// File: rtl/count_sequence_checker_if.sv
// Counter monitor bus: the sample strobe and count from the observed counter,
// plus the status the checker reports back.
interface count_sequence_checker_if #(
    parameter int COUNT_WIDTH = 3,
    parameter int ERR_WIDTH   = 8
);
    logic                   en;
    logic [COUNT_WIDTH-1:0] count_in;
    logic                   locked;
    logic                   err_pulse;
    logic [ERR_WIDTH-1:0]   err_count;
    logic [ERR_WIDTH-1:0]   wrap_count;
    logic [COUNT_WIDTH-1:0] expected;

    modport master (
        output en, count_in,
        input  locked, err_pulse, err_count, wrap_count, expected
    );

    modport slave (
        input  en, count_in,
        output locked, err_pulse, err_count, wrap_count, expected
    );
endinterface

// File: rtl/count_sequence_checker_sat_counter.sv
// Event counter that either saturates at all-ones or wraps modulo 2**WIDTH.
module sat_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !(SATURATE && (&count_q))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/count_sequence_checker.sv
// Integrity monitor for a wrapping up/down counter: locks onto the sequence
// after LOCK_LEN good samples, then pulses and counts every deviation.
module count_sequence_checker
    import count_pkg::*;
#(
    parameter int COUNT_WIDTH   = 3,
    parameter int UP_DOWN_COUNT = 1,
    parameter int COUNT_LIMIT   = 6,
    parameter int LOCK_LEN      = 3,
    parameter int ERR_WIDTH     = 8
) (
    input logic                     clk,
    input logic                     reset,
    count_sequence_checker_if.slave mon
);
    typedef logic [COUNT_WIDTH-1:0] count_t;

    localparam int     RUN_W    = $clog2(LOCK_LEN + 1);
    localparam count_t LIMIT_C  = count_t'(COUNT_LIMIT);
    localparam logic   UP_C     = (UP_DOWN_COUNT != 0);
    localparam count_t WRAP_V   = UP_C ? '0 : LIMIT_C;
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_LEN);

    state_e            state_q,    state_d;
    count_t            expected_q, expected_d;
    logic [RUN_W-1:0]  run_q,      run_d;
    logic              locked_q,   locked_d;
    logic              errPulse_q, errPulse_d;
    logic              errInc;
    logic              wrapInc;

    logic              inRange;
    logic              match;
    count_t            nextIn;
    logic [RUN_W-1:0]  runInc;

    assign inRange = (mon.count_in <= LIMIT_C);
    assign match   = (mon.count_in == expected_q);
    assign nextIn  = count_t'(next_count(wide_count_t'(mon.count_in),
                                         wide_count_t'(LIMIT_C), UP_C));
    assign runInc  = run_q + RUN_W'(1);

    // A mismatch only counts as an error once locked; before that it just reseeds.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_d      = run_q;
        locked_d   = locked_q;
        errPulse_d = 1'b0;
        errInc     = 1'b0;
        wrapInc    = 1'b0;
        if (mon.en) begin
            unique case (state_q)
                HUNT: begin
                    if (inRange) begin
                        expected_d = nextIn;
                        run_d      = RUN_W'(1);
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (match) begin
                        expected_d = nextIn;
                        run_d      = runInc;
                        if (runInc == RUN_LOCK) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (inRange) begin
                        expected_d = nextIn;
                        run_d      = RUN_W'(1);
                    end else begin
                        run_d   = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        expected_d = nextIn;
                        wrapInc    = (mon.count_in == WRAP_V);
                    end else begin
                        errPulse_d = 1'b1;
                        errInc     = 1'b1;
                        locked_d   = 1'b0;
                        if (inRange) begin
                            expected_d = nextIn;
                            run_d      = RUN_W'(1);
                            state_d    = SYNC;
                        end else begin
                            run_d   = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            expected_q <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            errPulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            errPulse_q <= errPulse_d;
        end
    end

    sat_counter #(.WIDTH(ERR_WIDTH), .SATURATE(1'b1)) errCounter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (errInc),
        .count_o (mon.err_count)
    );

    sat_counter #(.WIDTH(ERR_WIDTH), .SATURATE(1'b0)) wrapCounter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (wrapInc),
        .count_o (mon.wrap_count)
    );

    assign mon.locked    = locked_q;
    assign mon.err_pulse = errPulse_q;
    assign mon.expected  = expected_q;
endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: default up counter, a down counter,
// and a narrow error counter to exercise saturation and mid-stream reset.
module tb_count_sequence_checker;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   pulseSeen;

    count_sequence_checker_if #(.COUNT_WIDTH(3), .ERR_WIDTH(8)) ifA ();
    count_sequence_checker_if #(.COUNT_WIDTH(3), .ERR_WIDTH(8)) ifB ();
    count_sequence_checker_if #(.COUNT_WIDTH(3), .ERR_WIDTH(2)) ifC ();

    count_sequence_checker #(
        .COUNT_WIDTH(3), .UP_DOWN_COUNT(1), .COUNT_LIMIT(6), .LOCK_LEN(3), .ERR_WIDTH(8)
    ) dutA (.clk(clk), .reset(reset), .mon(ifA));

    count_sequence_checker #(
        .COUNT_WIDTH(3), .UP_DOWN_COUNT(0), .COUNT_LIMIT(6), .LOCK_LEN(3), .ERR_WIDTH(8)
    ) dutB (.clk(clk), .reset(reset), .mon(ifB));

    count_sequence_checker #(
        .COUNT_WIDTH(3), .UP_DOWN_COUNT(1), .COUNT_LIMIT(6), .LOCK_LEN(3), .ERR_WIDTH(2)
    ) dutC (.clk(clk), .reset(reset), .mon(ifC));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one sample into the selected checker (others idle), then settle past the edge.
    task automatic applyStimulus(input int sel, input logic e, input logic [2:0] v);
        ifA.en = (sel == 0) ? e : 1'b0;
        ifB.en = (sel == 1) ? e : 1'b0;
        ifC.en = (sel == 2) ? e : 1'b0;
        ifA.count_in = v;
        ifB.count_in = v;
        ifC.count_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    logic [2:0] cVals  [16] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd0, 3'd3, 3'd4,
                                3'd5, 3'd0, 3'd1, 3'd2, 3'd6, 3'd0, 3'd1, 3'd4};
    logic       cPulse [16] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic [1:0] cErr   [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        total     = 0;
        bad       = 0;
        pulseSeen = 0;
        reset     = 1'b1;
        ifA.en = 1'b0; ifB.en = 1'b0; ifC.en = 1'b0;
        ifA.count_in = '0; ifB.count_in = '0; ifC.count_in = '0;

        $display("[TB] reset");
        applyStimulus(0, 1'b0, 3'd0);
        applyStimulus(0, 1'b0, 3'd0);
        reset = 1'b0;
        checkOutput("rst_locked",   32'(ifA.locked),     32'd0);
        checkOutput("rst_pulse",    32'(ifA.err_pulse),  32'd0);
        checkOutput("rst_errcnt",   32'(ifA.err_count),  32'd0);
        checkOutput("rst_wrapcnt",  32'(ifA.wrap_count), 32'd0);
        checkOutput("rst_expected", 32'(ifA.expected),   32'd0);
        checkOutput("rstB_locked",  32'(ifB.locked),     32'd0);

        $display("[TB] up counter lock");
        applyStimulus(0, 1'b1, 3'd0);
        checkOutput("A0_locked", 32'(ifA.locked),   32'd0);
        checkOutput("A0_exp",    32'(ifA.expected), 32'd1);
        applyStimulus(0, 1'b1, 3'd1);
        checkOutput("A1_locked", 32'(ifA.locked),   32'd0);
        checkOutput("A1_exp",    32'(ifA.expected), 32'd2);
        applyStimulus(0, 1'b1, 3'd2);
        checkOutput("A2_locked", 32'(ifA.locked),    32'd1);
        checkOutput("A2_exp",    32'(ifA.expected),  32'd3);
        checkOutput("A2_pulse",  32'(ifA.err_pulse), 32'd0);

        $display("[TB] inject 4 for 3");
        applyStimulus(0, 1'b1, 3'd4);
        checkOutput("Ainj_pulse",  32'(ifA.err_pulse), 32'd1);
        checkOutput("Ainj_errcnt", 32'(ifA.err_count), 32'd1);
        checkOutput("Ainj_locked", 32'(ifA.locked),    32'd0);
        checkOutput("Ainj_exp",    32'(ifA.expected),  32'd5);
        applyStimulus(0, 1'b1, 3'd5);
        checkOutput("A5_pulse",  32'(ifA.err_pulse), 32'd0);
        checkOutput("A5_locked", 32'(ifA.locked),    32'd0);
        applyStimulus(0, 1'b1, 3'd6);
        checkOutput("A6_locked",  32'(ifA.locked),     32'd1);
        checkOutput("A6_wrapcnt", 32'(ifA.wrap_count), 32'd0);
        checkOutput("A6_exp",     32'(ifA.expected),   32'd0);

        $display("[TB] two wraps with idle gap");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 1'b1, 3'(i % 7));
            checkOutput("Arun_pulse", 32'(ifA.err_pulse), 32'd0);
            if (i == 3) begin
                for (int g = 0; g < 5; g++) applyStimulus(0, 1'b0, 3'd5);
                checkOutput("Agap_exp",     32'(ifA.expected),   32'd4);
                checkOutput("Agap_locked",  32'(ifA.locked),     32'd1);
                checkOutput("Agap_wrapcnt", 32'(ifA.wrap_count), 32'd1);
            end
        end
        checkOutput("Arun_wrapcnt", 32'(ifA.wrap_count), 32'd2);
        checkOutput("Arun_locked",  32'(ifA.locked),     32'd1);
        checkOutput("Arun_errcnt",  32'(ifA.err_count),  32'd1);
        checkOutput("Arun_exp",     32'(ifA.expected),   32'd0);

        $display("[TB] out-of-range while locked");
        applyStimulus(0, 1'b1, 3'd7);
        checkOutput("Aoor_pulse",  32'(ifA.err_pulse), 32'd1);
        checkOutput("Aoor_errcnt", 32'(ifA.err_count), 32'd2);
        checkOutput("Aoor_locked", 32'(ifA.locked),    32'd0);
        applyStimulus(0, 1'b1, 3'd0);
        checkOutput("Aseed_pulse",  32'(ifA.err_pulse), 32'd0);
        checkOutput("Aseed_errcnt", 32'(ifA.err_count), 32'd2);
        checkOutput("Aseed_exp",    32'(ifA.expected),  32'd1);
        applyStimulus(0, 1'b1, 3'd1);
        applyStimulus(0, 1'b1, 3'd2);
        checkOutput("Arelock", 32'(ifA.locked), 32'd1);

        $display("[TB] stalled counter and sync reseed");
        applyStimulus(0, 1'b1, 3'd2);
        checkOutput("Astall_pulse",  32'(ifA.err_pulse), 32'd1);
        checkOutput("Astall_errcnt", 32'(ifA.err_count), 32'd3);
        checkOutput("Astall_exp",    32'(ifA.expected),  32'd3);
        applyStimulus(0, 1'b1, 3'd5);
        checkOutput("Async_pulse", 32'(ifA.err_pulse), 32'd0);
        checkOutput("Async_exp",   32'(ifA.expected),  32'd6);
        applyStimulus(0, 1'b1, 3'd7);
        checkOutput("Ahunt_pulse",  32'(ifA.err_pulse), 32'd0);
        checkOutput("Ahunt_errcnt", 32'(ifA.err_count), 32'd3);
        applyStimulus(0, 1'b1, 3'd3);
        checkOutput("Ahunt_exp",    32'(ifA.expected),  32'd4);
        checkOutput("Ahunt_locked", 32'(ifA.locked),    32'd0);

        $display("[TB] down counter");
        applyStimulus(1, 1'b1, 3'd2);
        applyStimulus(1, 1'b1, 3'd1);
        applyStimulus(1, 1'b1, 3'd0);
        checkOutput("B0_locked",  32'(ifB.locked),     32'd1);
        checkOutput("B0_exp",     32'(ifB.expected),   32'd6);
        checkOutput("B0_wrapcnt", 32'(ifB.wrap_count), 32'd0);
        applyStimulus(1, 1'b1, 3'd6);
        checkOutput("B6_wrapcnt", 32'(ifB.wrap_count), 32'd1);
        applyStimulus(1, 1'b1, 3'd5);
        checkOutput("B5_exp",    32'(ifB.expected), 32'd4);
        checkOutput("B5_locked", 32'(ifB.locked),   32'd1);
        applyStimulus(1, 1'b1, 3'd4);
        applyStimulus(1, 1'b1, 3'd3);
        applyStimulus(1, 1'b1, 3'd2);
        checkOutput("B2_pulse", 32'(ifB.err_pulse), 32'd0);
        applyStimulus(1, 1'b1, 3'd2);
        checkOutput("Bstall_pulse",  32'(ifB.err_pulse), 32'd1);
        checkOutput("Bstall_errcnt", 32'(ifB.err_count), 32'd1);
        checkOutput("Bstall_locked", 32'(ifB.locked),    32'd0);
        checkOutput("Bstall_exp",    32'(ifB.expected),  32'd1);
        applyStimulus(1, 1'b0, 3'd0);
        checkOutput("Bidle_pulse",  32'(ifB.err_pulse), 32'd0);
        checkOutput("Bidle_errcnt", 32'(ifB.err_count), 32'd1);

        $display("[TB] saturating error counter");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2, 1'b1, cVals[i]);
            if (ifC.err_pulse === 1'b1) pulseSeen++;
            checkOutput($sformatf("C%0d_pulse", i),  32'(ifC.err_pulse), 32'(cPulse[i]));
            checkOutput($sformatf("C%0d_errcnt", i), 32'(ifC.err_count), 32'(cErr[i]));
        end
        checkOutput("C_pulsecount", 32'(pulseSeen), 32'd5);

        $display("[TB] reset mid-stream");
        reset = 1'b1;
        applyStimulus(2, 1'b1, 3'd5);
        reset = 1'b0;
        checkOutput("Crst_errcnt",  32'(ifC.err_count),  32'd0);
        checkOutput("Crst_locked",  32'(ifC.locked),     32'd0);
        checkOutput("Crst_exp",     32'(ifC.expected),   32'd0);
        checkOutput("Crst_pulse",   32'(ifC.err_pulse),  32'd0);
        checkOutput("Crst_Awrap",   32'(ifA.wrap_count), 32'd0);
        applyStimulus(2, 1'b1, 3'd0);
        applyStimulus(2, 1'b1, 3'd1);
        checkOutput("Crelock_early", 32'(ifC.locked), 32'd0);
        applyStimulus(2, 1'b1, 3'd2);
        checkOutput("Crelock", 32'(ifC.locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
